// File: rtl/restoring_divider_if.sv
// Start/done handshake bundle for restoring_divider: operands in, results and status out.
interface restoring_divider_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/restoring_divider.sv
// Sequential restoring divider, one shift/trial-subtract/restore step per clock.
// Define RESTORING_DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module restoring_divider #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   restoring_divider_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] ZERO = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] shifted, diff, r_step, q_step;
   logic [WIDTH-1:0] res_quo, res_rem, dividend_in, divisor_in;
   logic             sub_borrow, take, accept;

   assign shifted = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
   assign {sub_borrow, diff} = {1'b0, shifted} - {1'b0, dvs_q};
   // A bit shifted out of the partial remainder means the true value exceeds the
   // divisor, so the subtraction must succeed and the wrapped difference is exact.
   assign take   = r_q[WIDTH-1] | ~sub_borrow;
   assign r_step = take ? diff : shifted;
   assign q_step = {q_q[WIDTH-2:0], take};

`ifdef RESTORING_DIVIDER_SIGNED_EN
   logic neg_quo_q, neg_quo_d;
   logic neg_rem_q, neg_rem_d;

   assign dividend_in = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
   assign divisor_in  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
   assign res_quo     = neg_quo_q ? -q_step : q_step;
   assign res_rem     = neg_rem_q ? -r_step : r_step;

   always_comb begin
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      if (accept) begin
         neg_quo_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
         neg_rem_d = bus.dividend[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end
`else
   assign dividend_in = bus.dividend;
   assign divisor_in  = bus.divisor;
   assign res_quo     = q_step;
   assign res_rem     = r_step;
`endif

   assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      r_d         = r_q;
      q_d         = q_q;
      dvs_d       = dvs_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      case (state_q)
         IDLE: state_d = IDLE;
         RUN: begin
            r_d     = r_step;
            q_d     = q_step;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               state_d     = DONE;
               quotient_d  = res_quo;
               remainder_d = res_rem;
               dbz_d       = 1'b0;
            end
         end
         // q_q still holds the raw dividend captured on the zero-divisor start
         ZERO: begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = q_q;
            dbz_d       = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         if (bus.divisor == '0) begin
            state_d = ZERO;
            count_d = '0;
            r_d     = '0;
            q_d     = bus.dividend;
            dvs_d   = '0;
         end else begin
            state_d = RUN;
            count_d = CW'(WIDTH);
            r_d     = '0;
            q_d     = dividend_in;
            dvs_d   = divisor_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         count_q     <= '0;
         r_q         <= '0;
         q_q         <= '0;
         dvs_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         r_q         <= r_d;
         q_q         <= q_d;
         dvs_q       <= dvs_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign bus.busy        = (state_q == RUN);
   assign bus.done        = (state_q == DONE);
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = dbz_q;
endmodule
